// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared widths, FSM state encoding and the transfer-range helper for the DDR read arbiter.
package ddr_rd_arbiter_pkg;

  localparam int ADDR_W = 28;
  localparam int LEN_W  = 24;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STREAM = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // One-past-last word address; the carry bit flags a window that wraps the DDR space.
  function automatic logic [ADDR_W:0] xfer_end(input logic [ADDR_W-1:0] addr,
                                               input logic [LEN_W-1:0]  len);
    return {1'b0, addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
  endfunction

endpackage

// File: rtl/ddr_rd_skid.sv
// Two-entry valid/ready skid buffer between the DDR read FIFO and the granted consumer.
module ddr_rd_skid
  import ddr_rd_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [2];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        cnt_r;
  logic              push_s;
  logic              pop_s;

  assign out_valid = (cnt_r != 2'd0);
  assign out_data  = out_valid ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign pop_s     = out_valid & out_ready;
  assign push_s    = in_valid & ((cnt_r != 2'd2) | pop_s);
  assign count     = cnt_r;

  // Storage, pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= {DATA_W{1'b0}};
      mem_r[1] <= {DATA_W{1'b0}};
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      cnt_r <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin sharing of the ddr3_top read port between NUM_REQ consumers.
// Optional stall watchdog (parameter TIMEOUT) is built when DDR_RD_ARB_TIMEOUT_EN is defined.
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int LOAD_CYC   = 4,
  parameter int SETTLE_CYC = 16,
  parameter int BURST_LEN  = 64
`ifdef DDR_RD_ARB_TIMEOUT_EN
  , parameter int TIMEOUT  = 65535
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_done,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      dout_valid,
  output logic [DATA_W-1:0]         dout,
  input  logic                      dout_ready,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [ADDR_W-1:0]         app_addr_rd_min,
  output logic [ADDR_W-1:0]         app_addr_rd_max,
  output logic                      rd_load,
  output logic [7:0]                rd_bust_len,
  output logic                      rd_req,
  input  logic                      rd_empty,
  input  logic [DATA_W-1:0]         rddata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_r, state_nxt_s;
  logic [IDX_W-1:0]   ptr_r, ptr_nxt_s, win_r, win_nxt_s, pick_s, cand_s;
  logic [LEN_W-1:0]   len_r, len_nxt_s, issued_r, issued_nxt_s, accepted_r, accepted_nxt_s;
  logic [ADDR_W-1:0]  min_r, min_nxt_s, max_r, max_nxt_s, pick_addr_s;
  logic [LEN_W-1:0]   pick_len_s;
  logic [ADDR_W:0]    end_s;
  logic [15:0]        cnt_r, cnt_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s, done_r, done_nxt_s;
  logic               err_r, err_nxt_s, load_r, load_nxt_s;
  logic               found_s, refuse_s, inflight_r, issue_s, push_s, pop_s, flush_s;
  logic               skid_valid_s;
  logic [1:0]         occ_s;

  assign pick_addr_s = req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
  assign pick_len_s  = req_len[int'(pick_s)*LEN_W +: LEN_W];
  assign end_s       = xfer_end(pick_addr_s, pick_len_s);
  assign refuse_s    = end_s[ADDR_W] | (pick_len_s == {LEN_W{1'b0}});

  // Credit check counts a same-cycle pop so a full pipe still reads one word per cycle.
  assign pop_s   = skid_valid_s & dout_ready;
  assign push_s  = inflight_r & (state_r == ST_STREAM);
  assign issue_s = (state_r == ST_STREAM) && !rd_empty && (issued_r < len_r) &&
                   (({1'b0, occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));

  // Round-robin search starting at the pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

`ifdef DDR_RD_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_r;
  logic            wd_expire_s;

  assign wd_expire_s = (state_r == ST_STREAM) && !pop_s && (wd_r == WD_W'(TIMEOUT - 1));

  // Cycles in STREAM since the last accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= {WD_W{1'b0}};
    end else if ((state_r != ST_STREAM) || pop_s) begin
      wd_r <= {WD_W{1'b0}};
    end else begin
      wd_r <= wd_r + WD_W'(1);
    end
  end
`else
  logic wd_expire_s;
  assign wd_expire_s = 1'b0;
`endif

  // FSM next state and next values of every registered output.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    win_nxt_s      = win_r;
    len_nxt_s      = len_r;
    min_nxt_s      = min_r;
    max_nxt_s      = max_r;
    cnt_nxt_s      = cnt_r;
    issued_nxt_s   = issue_s ? issued_r + LEN_W'(1) : issued_r;
    accepted_nxt_s = pop_s ? accepted_r + LEN_W'(1) : accepted_r;
    grant_nxt_s    = grant_r;
    load_nxt_s     = load_r;
    done_nxt_s     = {NUM_REQ{1'b0}};
    err_nxt_s      = 1'b0;
    flush_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Hold off while a refusal's done is still visible so the requester can drop req.
        if (init_done && found_s && (done_r == {NUM_REQ{1'b0}})) begin
          if (pick_s == IDX_W'(NUM_REQ - 1)) begin
            ptr_nxt_s = {IDX_W{1'b0}};
          end else begin
            ptr_nxt_s = pick_s + IDX_W'(1);
          end
          if (refuse_s) begin
            done_nxt_s[pick_s] = 1'b1;
            err_nxt_s          = 1'b1;
          end else begin
            win_nxt_s           = pick_s;
            len_nxt_s           = pick_len_s;
            min_nxt_s           = pick_addr_s;
            max_nxt_s           = end_s[ADDR_W-1:0];
            grant_nxt_s[pick_s] = 1'b1;
            load_nxt_s          = 1'b1;
            cnt_nxt_s           = 16'd0;
            issued_nxt_s        = {LEN_W{1'b0}};
            accepted_nxt_s      = {LEN_W{1'b0}};
            state_nxt_s         = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_r == 16'(LOAD_CYC - 1)) begin
          load_nxt_s  = 1'b0;
          cnt_nxt_s   = 16'd0;
          state_nxt_s = ST_SETTLE;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == 16'(SETTLE_CYC - 1)) begin
          cnt_nxt_s   = 16'd0;
          state_nxt_s = ST_STREAM;
        end else begin
          cnt_nxt_s = cnt_r + 16'd1;
        end
      end
      ST_STREAM: begin
        if (accepted_r == len_r) begin
          done_nxt_s[win_r] = 1'b1;
          grant_nxt_s       = {NUM_REQ{1'b0}};
          state_nxt_s       = ST_FINISH;
        end else if (wd_expire_s) begin
          done_nxt_s[win_r] = 1'b1;
          err_nxt_s         = 1'b1;
          grant_nxt_s       = {NUM_REQ{1'b0}};
          flush_s           = 1'b1;
          state_nxt_s       = ST_IDLE;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_FINISH: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers: pointer, counters, window and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= {IDX_W{1'b0}};
      win_r      <= {IDX_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      issued_r   <= {LEN_W{1'b0}};
      accepted_r <= {LEN_W{1'b0}};
      min_r      <= {ADDR_W{1'b0}};
      max_r      <= {ADDR_W{1'b0}};
      cnt_r      <= 16'd0;
      grant_r    <= {NUM_REQ{1'b0}};
      done_r     <= {NUM_REQ{1'b0}};
      err_r      <= 1'b0;
      load_r     <= 1'b0;
      inflight_r <= 1'b0;
    end else begin
      ptr_r      <= ptr_nxt_s;
      win_r      <= win_nxt_s;
      len_r      <= len_nxt_s;
      issued_r   <= issued_nxt_s;
      accepted_r <= accepted_nxt_s;
      min_r      <= min_nxt_s;
      max_r      <= max_nxt_s;
      cnt_r      <= cnt_nxt_s;
      grant_r    <= grant_nxt_s;
      done_r     <= done_nxt_s;
      err_r      <= err_nxt_s;
      load_r     <= load_nxt_s;
      inflight_r <= issue_s;
    end
  end

  ddr_rd_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_s),
    .in_valid  (push_s),
    .in_data   (rddata),
    .out_valid (skid_valid_s),
    .out_data  (dout),
    .out_ready (dout_ready),
    .count     (occ_s)
  );

  assign grant           = grant_r;
  assign done            = done_r;
  assign err             = err_r;
  assign rd_load         = load_r;
  assign app_addr_rd_min = min_r;
  assign app_addr_rd_max = max_r;
  assign rd_bust_len     = 8'(BURST_LEN);
  assign rd_req          = issue_s;
  assign dout_valid      = skid_valid_s;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed, table-driven bench for ddr_rd_arbiter with a behavioural DDR read FIFO.
module tb_ddr_rd_arbiter;

  typedef struct {
    int          idx;
    logic [27:0] addr;
    logic [23:0] len;
    int          rdy;
    int          emp;
    bit          err;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1, init_done = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [55:0] req_addr = 56'd0;
  logic [47:0] req_len = 48'd0;
  logic [1:0]  grant, done;
  logic        dout_valid, err, rd_load, rd_req;
  logic [15:0] dout;
  logic        dout_ready = 1'b1, rd_empty = 1'b0;
  logic [27:0] app_addr_rd_min, app_addr_rd_max;
  logic [7:0]  rd_bust_len;
  logic [15:0] rddata = 16'd0, rd_count = 16'd0;

  int n_vec = 0, n_fail = 0, cyc = 0, rdy_mode = 0, emp_mode = 0;
  int n_done, n_err, n_load, nacc, first_valid, first_acc, last_acc, start;
  logic [1:0]  grant_seen, done_seen;
  logic [15:0] exp_word, prev_dout;
  bit          stall_prev, got_win;
  logic [27:0] got_min, got_max;
  vec_t        vecs[6];

  ddr_rd_arbiter #(
    .NUM_REQ(2), .LOAD_CYC(4), .SETTLE_CYC(16), .BURST_LEN(64)
`ifdef DDR_RD_ARB_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .req(req), .req_addr(req_addr),
    .req_len(req_len), .grant(grant), .dout_valid(dout_valid), .dout(dout),
    .dout_ready(dout_ready), .done(done), .err(err), .app_addr_rd_min(app_addr_rd_min),
    .app_addr_rd_max(app_addr_rd_max), .rd_load(rd_load), .rd_bust_len(rd_bust_len),
    .rd_req(rd_req), .rd_empty(rd_empty), .rddata(rddata)
  );

  always #5 clk = ~clk;

  // FIFO model: an incrementing word stream, data one cycle after rd_req.
  always @(posedge clk) begin
    if (rd_req) begin
      rddata   <= rd_count;
      rd_count <= rd_count + 16'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_track();
    n_done = 0; n_err = 0; n_load = 0; nacc = 0;
    first_valid = -1; first_acc = -1; last_acc = -1;
    grant_seen = 2'b00; done_seen = 2'b00; got_win = 1'b0; stall_prev = 1'b0;
  endtask

  // One clock: drive inputs on the falling edge, then observe the stable outputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    case (rdy_mode)
      1:       dout_ready = ~dout_ready;
      default: dout_ready = 1'b1;
    endcase
    case (emp_mode)
      0:       rd_empty = 1'b0;
      1:       if (cyc % 3 == 0) rd_empty = ~rd_empty;
      default: rd_empty = 1'b1;
    endcase
    if (stall_prev) check("dout_stable", {15'd0, dout_valid, dout}, {15'd0, 1'b1, prev_dout});
    check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    if (dout_valid && first_valid < 0) first_valid = cyc;
    if (dout_valid && dout_ready) begin
      check("word", 32'(dout), 32'(exp_word));
      exp_word = exp_word + 16'd1;
      nacc++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (rd_load) n_load++;
    if (err) n_err++;
    if (done != 2'b00) n_done++;
    done_seen  = done_seen | done;
    grant_seen = grant_seen | grant;
    if (grant != 2'b00 && !got_win) begin
      got_win = 1'b1; got_min = app_addr_rd_min; got_max = app_addr_rd_max;
    end
    stall_prev = dout_valid && !dout_ready;
    prev_dout  = dout;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rd_load"}, 32'(rd_load), 32'd0);
    check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_min"}, 32'(app_addr_rd_min), 32'd0);
    check({tag, "_max"}, 32'(app_addr_rd_max), 32'd0);
    check({tag, "_bust_len"}, 32'(rd_bust_len), 32'd64);
  endtask

  task automatic run(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.idx;
    clear_track();
    rdy_mode = v.rdy; emp_mode = v.emp; exp_word = rd_count;
    req_addr[v.idx*28 +: 28] = v.addr;
    req_len[v.idx*24 +: 24]  = v.len;
    req[v.idx] = 1'b1;
    start = cyc;
    for (int k = 0; k < 3000 && done_seen == 2'b00; k++) tick();
    req[v.idx] = 1'b0;
    check("done_which", 32'(done_seen), 32'(oh));
    repeat (4) tick();
    check("done_pulses", n_done, 1);
    check("err_pulses", n_err, v.err ? 1 : 0);
    check("load_cycles", n_load, v.err ? 0 : 4);
    check("grant_seen", 32'(grant_seen), v.err ? 32'd0 : 32'(oh));
    check("words", nacc, v.err ? 0 : int'(v.len));
    check("grant_after", 32'(grant), 32'd0);
    if (!v.err) begin
      check("win_min", 32'(got_min), 32'(v.addr));
      check("win_max", 32'(got_max), 32'(v.addr + 28'(v.len)));
      if (v.emp == 0) check("first_valid_lat", first_valid - start, 23);
      if (v.emp == 0 && v.rdy == 0) check("throughput", last_acc - first_acc, int'(v.len) - 1);
    end
  endtask

  initial begin
    int order[4];
    int ngr;
    logic [1:0] prevg, rearm;
    vecs[0] = '{0, 28'h0000000, 24'd8,   0, 0, 1'b0};
    vecs[1] = '{1, 28'h0000100, 24'd100, 1, 1, 1'b0};
    vecs[2] = '{0, 28'hFFFFFF0, 24'd32,  0, 0, 1'b1};
    vecs[3] = '{1, 28'h0000010, 24'd0,   0, 0, 1'b1};
    vecs[4] = '{0, 28'hFFFFFF0, 24'd15,  0, 0, 1'b0};
    vecs[5] = '{1, 28'hFFFFFF0, 24'd16,  0, 0, 1'b1};
    clear_track();
    exp_word = 16'd0;
    repeat (3) tick();
    check_quiet("in_reset");
    rst = 1'b0;
    tick();
    check_quiet("after_reset");

    // No grant while init_done is low.
    req_len[23:0] = 24'd8; req[0] = 1'b1;
    repeat (6) tick();
    check("no_grant_before_init", 32'(grant_seen), 32'd0);
    req = 2'b00; init_done = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Both requesters held and re-raised: strict alternation 0,1,0,1.
    clear_track();
    rdy_mode = 0; emp_mode = 0; exp_word = rd_count;
    req_addr = {28'h0000400, 28'h0000300}; req_len = {24'd4, 24'd4};
    req = 2'b11; ngr = 0; prevg = 2'b00; rearm = 2'b00;
    for (int k = 0; k < 2000 && n_done < 4; k++) begin
      tick();
      if (grant != 2'b00 && prevg == 2'b00 && ngr < 4) begin
        order[ngr] = (grant == 2'b10) ? 1 : 0;
        ngr++;
      end
      prevg = grant;
      req   = req | rearm;
      rearm = 2'b00;
      if (done != 2'b00) begin
        req   = req & ~done;
        rearm = done;
      end
    end
    req = 2'b00;
    repeat (3) tick();
    check("rr_grants", ngr, 4);
    for (int k = 0; k < 4; k++) check("rr_order", order[k], k % 2);
    check("rr_words", nacc, 16);
    check("rr_done", n_done, 4);

    // Reset in the middle of a 64-word transfer.
    clear_track();
    rdy_mode = 0; emp_mode = 0; exp_word = rd_count;
    req_addr[27:0] = 28'h0000200; req_len[23:0] = 24'd64; req[0] = 1'b1;
    for (int k = 0; k < 500 && nacc < 10; k++) tick();
    check("pre_reset_words", nacc, 10);
    rst = 1'b1; req = 2'b00;
    tick();
    check_quiet("mid_reset");
    rst = 1'b0;
    repeat (3) tick();
    check("no_done_after_abort", n_done, 0);
    run('{1, 28'h0000800, 24'd8, 0, 0, 1'b0});

`ifdef DDR_RD_ARB_TIMEOUT_EN
    // Watchdog: FIFO never delivers, abort after 20 idle STREAM cycles.
    clear_track();
    rdy_mode = 0; emp_mode = 2; exp_word = rd_count;
    req_addr[27:0] = 28'h0; req_len[23:0] = 24'd8; req[0] = 1'b1; start = cyc;
    for (int k = 0; k < 500 && done_seen == 2'b00; k++) tick();
    req = 2'b00;
    check("wd_latency", cyc - start, 41);
    check("wd_err", n_err, 1);
    repeat (3) tick();
    check("wd_done", n_done, 1);
    check("wd_words", nacc, 0);
    check("wd_grant_after", 32'(grant), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
